// File: rtl/sqrt_pipe_hs.sv
// Iterative non-restoring integer square root, K root bits per clock, valid/ready on both sides.
// Define SQRT_REM_EN to add the remainder output and its final sign correction.
module sqrt_pipe_hs #(
   parameter int N = 32,
   parameter int K = 1
) (
   input  logic             Clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     num_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N/2-1:0]   sq_root
`ifdef SQRT_REM_EN
   ,
   output logic [N/2:0]     remainder
`endif
);

   localparam int H  = N / 2;
   localparam int RW = H + 2;
   localparam int L  = N / (2 * K);
   localparam int CW = (L > 1) ? $clog2(L) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    r_state;
   logic [N-1:0]  r_num;
   logic [H-1:0]  r_q;
   logic [RW-1:0] r_r;
   logic [CW-1:0] r_cnt;

   logic [N-1:0]  w_num;
   logic [H-1:0]  w_q;
   logic [RW-1:0] w_r;
   logic [RW-1:0] w_rShift;
   logic          w_accept;
   logic          w_last;

   assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
   assign out_valid = (r_state == DONE);
   assign w_accept  = in_valid & in_ready;
   assign w_last    = (r_cnt == CW'(L - 1));

   // K unrolled iterations; the add/subtract choice uses the sign of the previous partial remainder
   always_comb begin
      w_num    = r_num;
      w_q      = r_q;
      w_r      = r_r;
      w_rShift = '0;
      for (int i = 0; i < K; i++) begin
         w_rShift = {w_r[RW-3:0], w_num[N-1:N-2]};
         w_r      = w_r[RW-1] ? (w_rShift + {w_q, 2'b11}) : (w_rShift - {w_q, 2'b01});
         w_q      = {w_q[H-2:0], ~w_r[RW-1]};
         w_num    = {w_num[N-3:0], 2'b00};
      end
   end

`ifdef SQRT_REM_EN
   logic [H:0] w_rem;

   // A negative final remainder is restored here so the fix-up costs no extra cycle
   always_comb begin
      w_rem = w_r[H:0];
      if (w_r[RW-1]) begin
         w_rem = w_r[H:0] + {w_q, 1'b1};
      end
   end
`endif

   // Control state plus operand capture and per-cycle iteration
   always_ff @(posedge Clock or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_num     <= '0;
         r_q       <= '0;
         r_r       <= '0;
         r_cnt     <= '0;
         sq_root   <= '0;
`ifdef SQRT_REM_EN
         remainder <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_state <= CALC;
               end
            end
            CALC: begin
               if (w_last) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_state <= in_valid ? CALC : IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase

         if (w_accept) begin
            r_num <= num_in;
            r_q   <= '0;
            r_r   <= '0;
            r_cnt <= '0;
         end else if (r_state == CALC) begin
            r_num <= w_num;
            r_q   <= w_q;
            r_r   <= w_r;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
               sq_root   <= w_q;
`ifdef SQRT_REM_EN
               remainder <= w_rem;
`endif
            end
         end
      end
   end

endmodule

// File: doc/sqrt_pipe_hs.md
Name: sqrt_pipe_hs

Overview:
Parametrised iterative non-restoring integer square-root unit with valid/ready handshakes on input and output.
- Computes floor(sqrt(num_in)) for an unsigned N-bit operand.
- Resolves K root bits per clock, giving a configurable area/latency trade-off.
- Sits between a streaming producer and consumer on the datapath, in place of a fixed 32-bit, fixed-latency, no-backpressure root block.

Parameters:
N, 32, operand width; must be even and >= 4.
K, 1, root bits resolved per clock; must divide N/2 exactly. L = N/(2K) is the number of compute cycles.

Ports:
Clock  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  num_in is valid.
in_ready  output  1  unit can accept an operand this cycle.
num_in  input  N  unsigned radicand.
out_valid  output  1  sq_root (and remainder) valid.
out_ready  input  1  consumer accepts the result this cycle.
sq_root  output  N/2  floor(sqrt(num_in)).
remainder  output  N/2+1  num_in - sq_root^2; present only with SQRT_REM_EN.

Behaviour:
- Reset (async, active-high): state=IDLE, out_valid=0, sq_root=0, remainder=0, all internal registers 0.
- Reset asserted mid-computation abandons the operation: no result is produced and the next operand is accepted normally.
- States:
  - IDLE: in_ready=1. On in_valid: capture num_in, clear the partial root q and signed partial remainder r (width N/2+2), go to CALC.
  - CALC: perform K non-restoring iterations per clock for L clocks (cycle counter 0..L-1).
    - Each iteration shifts the top two operand bits into r.
    - If r >= 0: r = r - {q,01}; else r = r + {q,11}.
    - Shift the bit ~r[MSB] into q.
    - After the last iteration: register sq_root=q, go to DONE.
  - DONE: out_valid=1. sq_root and remainder are held stable until out_ready.
    - On out_ready: if in_valid is also 1, capture the new operand and go to CALC; otherwise go to IDLE.
- in_ready = IDLE | (DONE & out_ready). This combinational path from out_ready is permitted.
- Latency: handshake at edge t, out_valid high after edge t+L. Best-case back-to-back throughput is one result per L+1 cycles.
- Inputs are ignored outside the handshake: num_in changes while in CALC do not affect the result.
- out_valid deasserts on the edge where out_valid & out_ready unless a new result is immediately ready; the latter cannot happen since L >= 1.
- Arithmetic is unsigned throughout. sq_root <= 2^(N/2)-1 for every input, so there is no overflow.
- Boundary values: num_in=0 gives 0; num_in=2^N-1 gives 2^(N/2)-1.

Optional Feature:
Macro SQRT_REM_EN.
- Defined: the remainder port exists.
  - If the final r is negative, the DONE-entry cycle applies a correction r = r + {q,1}, folded into the CALC→DONE transition; latency is unchanged.
  - remainder = r[N/2:0], range 0..2*sq_root.
- Undefined: the remainder port and correction logic are absent. sq_root behaviour and timing are identical.

Test Plan:
1. N=32, K=1: num_in=0, then 1, then 17 → sq_root 0, 1, 4; remainder 0, 0, 1; out_valid exactly 16 cycles after each handshake.
2. N=32, K=1: num_in=0xFFFFFFFF → sq_root=0xFFFF, remainder=0x1FFFE; num_in=1000000 → sq_root=1000, remainder=0.
3. Backpressure: hold out_ready=0 for 10 cycles after out_valid → sq_root stable, in_ready=0 throughout; release with in_valid=1, num_in=144 → new operand accepted on the same edge, result 12 after L cycles.
4. Reset pulse 5 cycles into CALC → out_valid stays 0; next operand 81 → 9 with normal latency.
5. N=16, K=4: num_in=0xFFFF → sq_root=0xFF, out_valid 2 cycles after handshake; random 1000-operand sweep matches the reference model, including with SQRT_REM_EN undefined.
